// File: rtl/alu_stream_pkg.sv
// Shared types for the streaming ALU: operation codes, control states and result flags.
package alu_stream_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_WB
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // Multiplicand shifts left and multiplier right, so bit i of b meets a<<i on iteration i.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  // High while the final iteration is being performed on the coming edge.
  assign done    = (cnt_q == CW'(1));
  assign product = acc_q;

endmodule

// File: rtl/alu_stream.sv
// Handshaked WIDTH-bit ALU with registered result/flags and a sequential multiply path.
module alu_stream
  import alu_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic               accept, out_free;
  logic               mul_start, mul_done, alu_write, wb_write, res_write;
  logic [2*WIDTH-1:0] product;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     alu_wide;
  logic [WIDTH-1:0]   alu_res, res_d, result_q;
  flags_t             alu_flags, flags_d, flags_q;
  logic               out_valid_q, out_valid_d;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  assign out_free = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && (op_e'(op) == OP_MUL)) state_d = ST_MUL;
      ST_MUL:  if (mul_done) state_d = ST_WB;
      ST_WB:   if (out_free) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state_q == ST_IDLE) && out_free;
    busy      = (state_q != ST_IDLE);
    mul_start = accept && (op_e'(op) == OP_MUL);
    alu_write = accept && (op_e'(op) != OP_MUL);
    wb_write  = (state_q == ST_WB) && out_free;
  end

  // Shifts run one bit wider so the last bit shifted out lands in alu_wide's spare bit.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    alu_wide  = '0;
    sh        = b[SHW-1:0];
    unique case (op_e'(op))
      OP_ADD: begin
        alu_wide           = {1'b0, a} + {1'b0, b};
        alu_res            = alu_wide[WIDTH-1:0];
        alu_flags.carry    = alu_wide[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res            = a - b;
        alu_flags.carry    = (a < b);
        alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_wide        = {1'b0, a} << sh;
        alu_res         = alu_wide[WIDTH-1:0];
        alu_flags.carry = alu_wide[WIDTH];
      end
      OP_SHR: begin
        alu_wide        = {a, 1'b0} >> sh;
        alu_res         = alu_wide[WIDTH:1];
        alu_flags.carry = alu_wide[0];
      end
      default: ;
    endcase
    alu_flags.zero     = (alu_res == '0);
    alu_flags.negative = alu_res[WIDTH-1];
  end

  always_comb begin
    if (state_q == ST_WB) begin
      res_d            = product[WIDTH-1:0];
      flags_d.zero     = (product[WIDTH-1:0] == '0);
      flags_d.carry    = |product[2*WIDTH-1:WIDTH];
      flags_d.overflow = 1'b0;
      flags_d.negative = product[WIDTH-1];
    end else begin
      res_d   = alu_res;
      flags_d = alu_flags;
    end
    res_write   = alu_write || wb_write;
    out_valid_d = res_write ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (res_write) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign negative  = flags_q.negative;

endmodule

// File: tb/tb_alu_stream.sv
// Self-checking bench for alu_stream: directed vector table, hand-written handshake sequences, randomized scoreboard.
module tb_alu_stream;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry, overflow, negative, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;   // {zero, carry, overflow, negative}
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {zero, carry, overflow, negative};
  endfunction

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, full, sh;
    logic [7:0] r;
    logic c, v;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    sh = uy % 8;
    c = 1'b0; v = 1'b0; r = '0; full = 0;
    case (o)
      3'd0: begin full = ux + uy; r = full[7:0]; c = (full > 255); v = (sx + sy > 127) || (sx + sy < -128); end
      3'd1: begin full = ux - uy; r = full[7:0]; c = (ux < uy);   v = (sx - sy > 127) || (sx - sy < -128); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin full = ux * (2 ** sh); r = full[7:0]; c = (sh != 0) && (((ux >> (8 - sh)) & 1) == 1); end
      3'd6: begin full = ux / (2 ** sh); r = full[7:0]; c = (sh != 0) && (((ux >> (sh - 1)) & 1) == 1); end
      default: begin full = ux * uy; r = full[7:0]; c = (full > 255); end
    endcase
    return {r, (r == 8'h00), c, v, r[7]};
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] r, output logic [3:0] f, output int lat);
    int i;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    i = 0;
    while (!in_ready && i < 50) begin @(negedge clk); #1; i++; end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); #1; lat++; end
    check("result_wait", 32'(out_valid), 32'd1);
    r = result;
    f = dut_flags();
  endtask

  initial begin
    logic [7:0]  r;
    logic [3:0]  f;
    int          lat;
    logic [11:0] q[$];
    logic [11:0] exp;
    logic        stalled, seen;
    logic [11:0] held;

    vecs[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 4'b0100};
    vecs[1]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0010};
    vecs[2]  = '{3'd1, 8'h05, 8'h05, 8'h00, 4'b1000};
    vecs[3]  = '{3'd5, 8'h81, 8'h01, 8'h02, 4'b0100};
    vecs[4]  = '{3'd6, 8'h81, 8'h00, 8'h81, 4'b0001};
    vecs[5]  = '{3'd7, 8'h12, 8'h10, 8'h20, 4'b0100};
    vecs[6]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[7]  = '{3'd3, 8'h0F, 8'h80, 8'h8F, 4'b0001};
    vecs[8]  = '{3'd4, 8'hAA, 8'hAA, 8'h00, 4'b1000};
    vecs[9]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011};
    vecs[10] = '{3'd6, 8'hC1, 8'h07, 8'h01, 4'b0100};
    vecs[11] = '{3'd5, 8'h01, 8'h07, 8'h80, 4'b0001};
    vecs[12] = '{3'd5, 8'h40, 8'h09, 8'h80, 4'b0001};
    vecs[13] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 4'b0100};
    vecs[14] = '{3'd7, 8'h0F, 8'h03, 8'h2D, 4'b0000};
    vecs[15] = '{3'd1, 8'h00, 8'h01, 8'hFF, 4'b0101};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(dut_flags()), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].fl));
      check($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].op == 3'd7) ? 32'(W + 1) : 32'd0);
    end

    // Multiply: busy and in_ready over the iteration window
    @(negedge clk);
    op = 3'd7; a = 8'h12; b = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("mul_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      check($sformatf("mul_no_early_k%0d", k), 32'(out_valid), 32'd0);
      check($sformatf("mul_in_ready_k%0d", k), 32'(in_ready), 32'd0);
      if (k < 8) check($sformatf("mul_busy_k%0d", k), 32'(busy), 32'd1);
    end
    @(negedge clk);
    #1;
    check("mul_out_valid", 32'(out_valid), 32'd1);
    check("mul_result", 32'(result), 32'h20);
    check("mul_carry", 32'(carry), 32'd1);
    check("mul_busy_done", 32'(busy), 32'd0);

    // Backpressure: three back-to-back ops behind a stalled sink
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = 8'h11; b = 8'h22;
    #1;
    check("bp_first_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    op = 3'd2; a = 8'hF0; b = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      check($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_result_c%0d", c), 32'(result), 32'h33);
      check($sformatf("bp_hold_ready_c%0d", c), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_add_result", 32'(result), 32'h33);
    @(negedge clk);
    op = 3'd3; a = 8'h0F; b = 8'h80;
    #1;
    check("bp_and_valid", 32'(out_valid), 32'd1);
    check("bp_and_result", 32'(result), 32'h30);
    check("bp_and_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_or_valid", 32'(out_valid), 32'd1);
    check("bp_or_result", 32'(result), 32'h8F);
    @(negedge clk);
    #1;
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 3'd7; a = 8'h12; b = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("rmul_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rmul_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmul_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmul_out_valid", 32'(out_valid), 32'd0);
    check("rmul_busy_clear", 32'(busy), 32'd0);
    check("rmul_result", 32'(result), 32'd0);
    check("rmul_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("rmul_no_product", 32'(seen), 32'd0);
    do_op(3'd0, 8'h05, 8'h03, r, f, lat);
    check("rmul_add_result", 32'(r), 32'h08);
    check("rmul_add_flags", 32'(f), 32'd0);

    // Randomized stream against the reference model
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        check("rand_hold_valid", 32'(out_valid), 32'd1);
        check("rand_hold_data", 32'({result, dut_flags()}), 32'(held));
      end
      if (out_valid && out_ready) begin
        check("rand_expected_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          check("rand_result", 32'(result), 32'(exp[11:4]));
          check("rand_flags", 32'(dut_flags()), 32'(exp[3:0]));
        end
      end
      if (in_valid && in_ready) q.push_back(model(op, a, b));
      stalled = out_valid && !out_ready;
      held    = {result, dut_flags()};
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && (q.size() != 0 || out_valid); k++) begin
      #1;
      if (out_valid && q.size() != 0) begin
        exp = q.pop_front();
        check("drain_result", 32'(result), 32'(exp[11:4]));
        check("drain_flags", 32'(dut_flags()), 32'(exp[3:0]));
      end
      @(negedge clk);
    end
    #1;
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
